fpu_issuer: RTL and testbench

Initiator side of the FPU operand/result handshake. Buffers commands (operation plus two IEEE-754 single operands) in a small FIFO and issues them one at a time to `fpu` over input_rdy/input_ack. It collects each result over output_rdy/output_ack and presents it on a valid/ready response port. It sits between the core's execute stage and the `fpu` instance and replaces bench-style hand driving of the handshake.

---
 rtl/fpu_pkg.sv | 30 +++
 rtl/fpu_cmd_fifo.sv | 55 +++++
 rtl/fpu_issuer.sv | 142 ++++++++++++++
 tb/tb_fpu_issuer.sv | 542 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types for the FPU issuer: operation codes, the NaN abort pattern,
// the buffered command word and the issuer state encoding.
package fpu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_MUL = 4'b0010,
    OP_DIV = 4'b0011
  } Operation_t;

  // Returned in place of a result when the fpu never answers.
  localparam logic [31:0] FPU_NAN = 32'hFFFF_FFFF;

  // Op is kept as raw bits so unknown codes pass through untouched.
  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_ACK,
    ST_DONE
  } issuer_state_t;

endpackage

// File: rtl/fpu_cmd_fifo.sv
// Command FIFO for the FPU issuer: DEPTH entries of {op, a, b}, registered
// occupancy count, show-ahead read port.
module fpu_cmd_fifo
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_en,
  input  cmd_t                   wr_data,
  input  logic                   rd_en,
  output cmd_t                   rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fpu_issuer.sv
// FPU issuer: queues commands, drives one at a time into the fpu over the
// input_rdy/input_ack handshake, collects the result over output_rdy/output_ack
// and holds it on a valid/ready response port.
//
//   state | meaning
//   IDLE  | nothing in flight; discards stale fpu results, else pops next command
//   ISSUE | operands held on input_rdy until the fpu acknowledges them
//   WAIT  | operands accepted, waiting for output_rdy
//   ACK   | result captured, waiting for the fpu to drop output_rdy
//   DONE  | response held on rsp_valid until rsp_ready
module fpu_issuer
  import fpu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_op,
  output logic        rsp_err,
  output logic [3:0]  operation,
  output logic [31:0] data_a,
  output logic [31:0] data_b,
  output logic        input_rdy,
  input  logic        input_ack,
  input  logic        output_rdy,
  output logic        output_ack,
  input  logic [31:0] result,
  output logic        busy
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT);

  issuer_state_t          state;
  logic [TW-1:0]          timer;
  cmd_t                   cmd_in;
  cmd_t                   head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   pop;

  assign cmd_in    = '{op: cmd_op, a: cmd_a, b: cmd_b};
  assign cmd_ready = !fifo_full;
  // A stale result pending in IDLE blocks issue until it has been drained.
  assign pop       = (state == ST_IDLE) && !output_rdy && !fifo_empty;
  assign busy      = (state != ST_IDLE) || (fifo_count != '0);

  fpu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (cmd_valid),
    .wr_data (cmd_in),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Issue/collect sequencer with a down-counting abort timer; all outputs registered.
  // The timer is loaded on issue and aborts when it reaches zero, i.e. TIMEOUT
  // cycles after the first ISSUE cycle; output_rdy in that same cycle still wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      timer      <= '0;
      operation  <= '0;
      data_a     <= '0;
      data_b     <= '0;
      input_rdy  <= 1'b0;
      output_ack <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_op     <= '0;
      rsp_err    <= 1'b0;
    end else begin
      output_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (output_rdy) begin
            // Ack only once; the fpu drops output_rdy on the edge that sees the ack.
            if (!output_ack) output_ack <= 1'b1;
          end else if (pop) begin
            operation <= head.op;
            data_a    <= head.a;
            data_b    <= head.b;
            input_rdy <= 1'b1;
            timer     <= TIMER_LOAD;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE, ST_WAIT: begin
          if (output_rdy && (state == ST_WAIT || input_ack)) begin
            rsp_result <= result;
            rsp_op     <= operation;
            rsp_err    <= 1'b0;
            input_rdy  <= 1'b0;
            output_ack <= 1'b1;
            state      <= ST_ACK;
          end else if (timer == '0) begin
            rsp_result <= FPU_NAN;
            rsp_op     <= operation;
            rsp_err    <= 1'b1;
            input_rdy  <= 1'b0;
            rsp_valid  <= 1'b1;
            state      <= ST_DONE;
          end else begin
            timer <= timer - 1'b1;
            if (state == ST_ISSUE && input_ack) begin
              input_rdy <= 1'b0;
              state     <= ST_WAIT;
            end
          end
        end
        ST_ACK: begin
          if (!output_rdy) begin
            rsp_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_issuer.sv
// Bench for fpu_issuer: behavioural fpu stub plus an ordered queue of expected
// responses (op, result or NaN, error flag) built as commands are accepted.
module tb_fpu_issuer;
  import fpu_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  localparam int M_NORMAL = 0;  // ack, then result after stub_lat cycles
  localparam int M_NEVER  = 1;  // ack, result withheld while in this mode
  localparam int M_SAME   = 2;  // ack and result in the same cycle
  localparam int M_STALL  = 3;  // never ack

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = '0;
  logic [31:0] cmd_a = '0;
  logic [31:0] cmd_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_op;
  logic        rsp_err;
  logic [3:0]  operation;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic        input_rdy;
  logic        input_ack;
  logic        output_rdy;
  logic        output_ack;
  logic [31:0] result;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] res;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  always #5 clock = ~clock;

  fpu_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_err(rsp_err),
    .operation(operation), .data_a(data_a), .data_b(data_b),
    .input_rdy(input_rdy), .input_ack(input_ack), .output_rdy(output_rdy), .output_ack(output_ack),
    .result(result), .busy(busy)
  );

  // Stand-in for the fpu datapath: exact answers for the directed vectors,
  // an arbitrary but deterministic mix otherwise.
  function automatic logic [31:0] stub_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == OP_ADD && a == 32'h3F80_0000 && b == 32'h3C23_D70A) return 32'h3F81_47AE;
    if (op == OP_MUL && a == 32'h4000_0000 && b == 32'h4000_0000) return 32'h4080_0000;
    if (op == OP_DIV && a == 32'h4080_0000 && b == 32'h4000_0000) return 32'h4000_0000;
    return a ^ {b[15:0], b[31:16]} ^ {28'h0, op} ^ 32'h5A5A_0000;
  endfunction

  // Behavioural fpu
  int          stub_mode = M_NORMAL;
  int          stub_lat  = 3;
  logic        s_busy;
  int          s_cnt;
  logic [31:0] s_res;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      input_ack  <= 1'b0;
      output_rdy <= 1'b0;
      result     <= '0;
      s_busy     <= 1'b0;
      s_cnt      <= 0;
      s_res      <= '0;
    end else begin
      input_ack <= 1'b0;
      if (output_rdy) begin
        if (output_ack) begin
          output_rdy <= 1'b0;
          s_busy     <= 1'b0;
        end
      end else if (s_busy) begin
        if (s_cnt != 0) s_cnt <= s_cnt - 1;
        else if (stub_mode != M_NEVER) begin
          output_rdy <= 1'b1;
          result     <= s_res;
        end
      end else if (input_rdy && !input_ack && stub_mode != M_STALL) begin
        input_ack <= 1'b1;
        s_busy    <= 1'b1;
        s_res     <= stub_calc(operation, data_a, data_b);
        if (stub_mode == M_SAME) begin
          output_rdy <= 1'b1;
          result     <= stub_calc(operation, data_a, data_b);
        end else begin
          s_cnt <= ((stub_lat == 0) ? int'($urandom_range(8, 1)) : stub_lat) - 1;
        end
      end
    end
  end

  // Handshake monitor
  int   cyc = 0, n_hs = 0, n_oack = 0, n_dbl = 0, n_overlap = 0, hs_cyc = 0, oack_cyc = 0;
  logic oack_q = 1'b0;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (input_rdy && input_ack) begin
      n_hs   <= n_hs + 1;
      hs_cyc <= cyc;
    end
    if (output_ack) begin
      n_oack   <= n_oack + 1;
      oack_cyc <= cyc;
    end
    if (output_ack && oack_q) n_dbl <= n_dbl + 1;
    oack_q <= output_ack;
    if (input_rdy && rsp_valid) n_overlap <= n_overlap + 1;
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit to);
    int n = 0;
    while (!cmd_ready && n < 300) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (!cmd_ready) begin
      errors++;
      $display("FAIL send_cmd_ready cmd_ready=%b required 1", cmd_ready);
    end else begin
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      exp_q.push_back('{op, to ? FPU_NAN : stub_calc(op, a, b), to});
      @(negedge clock);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_rsp_valid(input int budget, output bit ok);
    int n = 0;
    while (!rsp_valid && n < budget) begin
      @(negedge clock);
      n++;
    end
    ok = rsp_valid;
  endtask

  task automatic take_rsp(output logic [31:0] res, output logic [3:0] op, output logic err);
    res       = rsp_result;
    op        = rsp_op;
    err       = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1 reset = 1'b1;
    #10;
    checks++;
    if ({input_rdy, output_ack, rsp_valid, rsp_err, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b required 00000", {input_rdy, output_ack, rsp_valid, rsp_err, busy});
    end
    checks++;
    if ({operation, data_a, data_b, rsp_result, rsp_op} !== '0) begin
      errors++;
      $display("FAIL reset_data op=%h a=%h b=%h res=%h rop=%h required all 0", operation, data_a, data_b, rsp_result, rsp_op);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_cmd_ready got %b required 1", cmd_ready);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_single_add();
    int h0, o0, d0;
    bit ok;
    logic [31:0] r;
    logic [3:0] op;
    logic e;
    stub_mode = M_NORMAL;
    stub_lat  = 3;
    h0 = n_hs; o0 = n_oack; d0 = n_dbl;
    send_cmd(OP_ADD, 32'h3F80_0000, 32'h3C23_D70A, 1'b0);
    checks++;
    if (input_rdy !== 1'b0) begin
      errors++;
      $display("FAIL add_issue_early input_rdy=%b required 0", input_rdy);
    end
    @(negedge clock);
    checks++;
    if ({input_rdy, operation, data_a, data_b} !== {1'b1, 4'h0, 32'h3F80_0000, 32'h3C23_D70A}) begin
      errors++;
      $display("FAIL add_issue rdy=%b op=%h a=%h b=%h required 1/0/3f800000/3c23d70a", input_rdy, operation, data_a, data_b);
    end
    wait_rsp_valid(100, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL add_rsp_timeout rsp_valid=%b required 1", rsp_valid);
    end else begin
      exp_t x;
      take_rsp(r, op, e);
      x = exp_q.pop_front();
      checks++;
      if ({r, op, e} !== {32'h3F81_47AE, 4'h0, 1'b0} || {r, op, e} !== {x.res, x.op, x.err}) begin
        errors++;
        $display("FAIL add_rsp got res=%h op=%h err=%b required 3f8147ae/0/0", r, op, e);
      end
    end
    checks++;
    if ((n_hs - h0) != 1 || (n_oack - o0) != 1 || n_dbl != d0) begin
      errors++;
      $display("FAIL add_handshakes in=%0d oack=%0d dbl=%0d required 1/1/0", n_hs - h0, n_oack - o0, n_dbl - d0);
    end
  endtask

  task automatic test_back_to_back();
    int v0;
    bit ok;
    logic [31:0] r;
    logic [3:0] op;
    logic e;
    stub_mode = M_NORMAL;
    stub_lat  = 4;
    v0 = n_overlap;
    send_cmd(OP_MUL, 32'h4000_0000, 32'h4000_0000, 1'b0);
    send_cmd(OP_DIV, 32'h4080_0000, 32'h4000_0000, 1'b0);
    wait_rsp_valid(100, ok);
    repeat (5) @(negedge clock);
    checks++;
    if (!ok || input_rdy !== 1'b0 || rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_hold rsp_valid=%b input_rdy=%b required 1/0", rsp_valid, input_rdy);
    end
    take_rsp(r, op, e);
    checks++;
    if ({r, op, e} !== {32'h4080_0000, OP_MUL, 1'b0}) begin
      errors++;
      $display("FAIL b2b_first got res=%h op=%h err=%b required 40800000/2/0", r, op, e);
    end
    wait_rsp_valid(100, ok);
    take_rsp(r, op, e);
    checks++;
    if (!ok || {r, op, e} !== {32'h4000_0000, OP_DIV, 1'b0}) begin
      errors++;
      $display("FAIL b2b_second got res=%h op=%h err=%b required 40000000/3/0", r, op, e);
    end
    exp_q.delete();
    checks++;
    if (n_overlap != v0) begin
      errors++;
      $display("FAIL b2b_overlap cycles=%0d required 0", n_overlap - v0);
    end
  endtask

  task automatic test_fill();
    bit ok;
    logic [31:0] r;
    logic [3:0] op;
    logic e;
    exp_t x;
    stub_mode = M_NORMAL;
    stub_lat  = 2;
    send_cmd(OP_SUB, $urandom, $urandom, 1'b0);
    wait_rsp_valid(100, ok);
    for (int i = 0; i < DEPTH; i++) send_cmd(4'($urandom_range(3, 0)), $urandom, $urandom, 1'b0);
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_full cmd_ready=%b required 0", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op    = OP_ADD;
    cmd_a     = 32'hDEAD_BEEF;
    cmd_b     = 32'h1234_5678;
    @(negedge clock);
    cmd_valid = 1'b0;
    checks++;
    if ({cmd_ready, busy} !== 2'b01) begin
      errors++;
      $display("FAIL fill_still_full cmd_ready=%b busy=%b required 0/1", cmd_ready, busy);
    end
    for (int i = 0; i <= DEPTH; i++) begin
      wait_rsp_valid(100, ok);
      checks++;
      if (!ok || exp_q.size() == 0) begin
        errors++;
        $display("FAIL fill_rsp_%0d rsp_valid=%b queued=%0d required 1/>0", i, rsp_valid, exp_q.size());
      end else begin
        take_rsp(r, op, e);
        x = exp_q.pop_front();
        checks++;
        if ({r, op, e} !== {x.res, x.op, x.err}) begin
          errors++;
          $display("FAIL fill_data_%0d got %h/%h/%b required %h/%h/%b", i, r, op, e, x.res, x.op, x.err);
        end
      end
    end
    repeat (20) @(negedge clock);
    checks++;
    if ({rsp_valid, busy, cmd_ready} !== 3'b001) begin
      errors++;
      $display("FAIL fill_drained rsp_valid=%b busy=%b cmd_ready=%b required 0/0/1", rsp_valid, busy, cmd_ready);
    end
  endtask

  task automatic test_same_cycle();
    int o0, d0;
    bit ok;
    logic [31:0] r;
    logic [3:0] op;
    logic e;
    logic [31:0] a, b;
    stub_mode = M_SAME;
    o0 = n_oack; d0 = n_dbl;
    a = $urandom; b = $urandom;
    send_cmd(OP_SUB, a, b, 1'b0);
    wait_rsp_valid(100, ok);
    take_rsp(r, op, e);
    void'(exp_q.pop_front());
    checks++;
    if (!ok || {r, op, e} !== {stub_calc(OP_SUB, a, b), OP_SUB, 1'b0}) begin
      errors++;
      $display("FAIL same_rsp got %h/%h/%b required %h/1/0", r, op, e, stub_calc(OP_SUB, a, b));
    end
    checks++;
    if ((n_oack - o0) != 1 || n_dbl != d0 || oack_cyc != hs_cyc + 1) begin
      errors++;
      $display("FAIL same_ack pulses=%0d dbl=%0d ack_at=%0d required 1/0/%0d", n_oack - o0, n_dbl - d0, oack_cyc, hs_cyc + 1);
    end
    stub_mode = M_NORMAL;
  endtask

  task automatic test_timeout();
    int n, o0;
    bit ok;
    logic [31:0] r;
    logic [3:0] op;
    logic e;
    // no ack at all: abort latency measured from the first input_rdy cycle
    stub_mode = M_STALL;
    send_cmd(OP_MUL, $urandom, $urandom, 1'b1);
    @(negedge clock);
    n = 0;
    while (!rsp_valid && n < 300) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (n != TIMEOUT + 1 || input_rdy !== 1'b0) begin
      errors++;
      $display("FAIL to_latency cycles=%0d input_rdy=%b required %0d/0", n, input_rdy, TIMEOUT + 1);
    end
    take_rsp(r, op, e);
    void'(exp_q.pop_front());
    checks++;
    if ({r, op, e} !== {32'hFFFF_FFFF, OP_MUL, 1'b1}) begin
      errors++;
      $display("FAIL to_rsp got %h/%h/%b required ffffffff/2/1", r, op, e);
    end
    // acked but no result; the late result is later drained as stale
    stub_mode = M_NEVER;
    stub_lat  = 2;
    o0 = n_oack;
    send_cmd(OP_DIV, $urandom, $urandom, 1'b1);
    wait_rsp_valid(200, ok);
    take_rsp(r, op, e);
    void'(exp_q.pop_front());
    checks++;
    if (!ok || {r, op, e} !== {32'hFFFF_FFFF, OP_DIV, 1'b1}) begin
      errors++;
      $display("FAIL to_acked_rsp got %h/%h/%b required ffffffff/3/1", r, op, e);
    end
    stub_mode = M_NORMAL;
    repeat (10) @(negedge clock);
    checks++;
    if ((n_oack - o0) != 1 || rsp_valid !== 1'b0 || busy !== 1'b0 || output_rdy !== 1'b0) begin
      errors++;
      $display("FAIL stale_drain acks=%0d rsp_valid=%b busy=%b output_rdy=%b required 1/0/0/0", n_oack - o0, rsp_valid, busy, output_rdy);
    end
  endtask

  task automatic test_boundary();
    int o0;
    bit ok;
    logic [31:0] r;
    logic [3:0] op;
    logic e;
    logic [31:0] a, b;
    // result arrives in the abort cycle: normal completion
    stub_mode = M_NORMAL;
    stub_lat  = TIMEOUT - 1;
    a = $urandom; b = $urandom;
    send_cmd(OP_ADD, a, b, 1'b0);
    wait_rsp_valid(200, ok);
    take_rsp(r, op, e);
    void'(exp_q.pop_front());
    checks++;
    if (!ok || {r, op, e} !== {stub_calc(OP_ADD, a, b), OP_ADD, 1'b0}) begin
      errors++;
      $display("FAIL edge_in_time got %h/%h/%b required %h/0/0", r, op, e, stub_calc(OP_ADD, a, b));
    end
    // one cycle later: abort, then the late result is discarded
    stub_lat = TIMEOUT;
    o0 = n_oack;
    send_cmd(OP_SUB, a, b, 1'b1);
    wait_rsp_valid(200, ok);
    take_rsp(r, op, e);
    void'(exp_q.pop_front());
    checks++;
    if (!ok || {r, op, e} !== {32'hFFFF_FFFF, OP_SUB, 1'b1}) begin
      errors++;
      $display("FAIL edge_late got %h/%h/%b required ffffffff/1/1", r, op, e);
    end
    repeat (10) @(negedge clock);
    checks++;
    if ((n_oack - o0) != 1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL edge_stale acks=%0d rsp_valid=%b busy=%b required 1/0/0", n_oack - o0, rsp_valid, busy);
    end
  endtask

  task automatic test_random();
    localparam int N = 24;
    stub_mode = M_NORMAL;
    stub_lat  = 0;
    fork
      begin
        for (int i = 0; i < N; i++) begin
          repeat ($urandom_range(2, 0)) @(negedge clock);
          send_cmd(4'($urandom_range(15, 0)), $urandom, $urandom, 1'b0);
        end
      end
      begin
        bit ok;
        logic [31:0] r;
        logic [3:0] op;
        logic e;
        exp_t x;
        for (int k = 0; k < N; k++) begin
          wait_rsp_valid(200, ok);
          repeat ($urandom_range(3, 0)) @(negedge clock);
          checks++;
          if (!ok || exp_q.size() == 0) begin
            errors++;
            $display("FAIL rand_rsp_%0d rsp_valid=%b queued=%0d required 1/>0", k, rsp_valid, exp_q.size());
          end else begin
            take_rsp(r, op, e);
            x = exp_q.pop_front();
            checks++;
            if ({r, op, e} !== {x.res, x.op, x.err}) begin
              errors++;
              $display("FAIL rand_data_%0d got %h/%h/%b required %h/%h/%b", k, r, op, e, x.res, x.op, x.err);
            end
          end
        end
      end
    join
    stub_lat = 3;
  endtask

  task automatic test_reset_mid();
    int h0, n, seen;
    stub_mode = M_NORMAL;
    stub_lat  = 20;
    h0 = n_hs;
    send_cmd(OP_MUL, $urandom, $urandom, 1'b0);
    send_cmd(OP_ADD, $urandom, $urandom, 1'b0);
    send_cmd(OP_DIV, $urandom, $urandom, 1'b0);
    n = 0;
    while (n_hs == h0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    repeat (3) @(negedge clock);
    checks++;
    if (n_hs == h0 || input_rdy !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_setup accepted=%0d input_rdy=%b busy=%b required 1/0/1", n_hs - h0, input_rdy, busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({input_rdy, output_ack, rsp_valid, rsp_err, busy, cmd_ready} !== 6'b000001 ||
        {operation, data_a, data_b, rsp_result, rsp_op} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs ctrl=%b op=%h a=%h b=%h res=%h rop=%h required 000001 and zero data",
               {input_rdy, output_ack, rsp_valid, rsp_err, busy, cmd_ready}, operation, data_a, data_b, rsp_result, rsp_op);
    end
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (rsp_valid || input_rdy || busy) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rst_mid_quiet active_cycles=%0d required 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_back_to_back();
    test_fill();
    test_same_cycle();
    test_timeout();
    test_boundary();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
